// File: rtl/async_mem_bridge.sv
// Synchronous master for a four-phase dual-rail asynchronous memory port.
// One command at a time: encode, request, capture, return-to-null, respond.
module async_mem_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_data_in,
  output logic [1:0]  mem_read_Nwrite,
  output logic        mem_ack_in_read,
  input  logic [15:0] mem_data_out,
  input  logic        mem_ack_read,
  input  logic        mem_ack_write
);

  // state  | meaning
  // IDLE   | waiting for a command, acks released
  // W_REQ  | write codewords + write request driven, waiting for ack_write
  // W_RTZ  | outputs null, waiting for ack_write release
  // R_REQ  | address + read request driven, waiting for ack_read
  // R_CAP  | decode read data
  // R_ACK  | read data consumed ack driven, waiting for ack_read release
  // R_REL  | consumed ack dropped
  // RESP   | one-cycle response pulse
  // ERR    | timeout recovery, waiting for both acks to release
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_W_REQ = 4'd1;
  localparam logic [3:0] S_W_RTZ = 4'd2;
  localparam logic [3:0] S_R_REQ = 4'd3;
  localparam logic [3:0] S_R_CAP = 4'd4;
  localparam logic [3:0] S_R_ACK = 4'd5;
  localparam logic [3:0] S_R_REL = 4'd6;
  localparam logic [3:0] S_RESP  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [3:0]             state, state_nx;
  logic [CW-1:0]          cnt;
  logic                   tmo, counting, err_q;
  logic [SYNC_STAGES-1:0] ar_sync, aw_sync;
  logic                   ar_s, aw_s;
  logic [7:0]             cap_data;
  logic                   cap_bad;

  function automatic logic [7:0] dr_enc4(input logic [3:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = {v[i], ~v[i]};
    return r;
  endfunction

  function automatic logic [15:0] dr_enc8(input logic [7:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = {v[i], ~v[i]};
    return r;
  endfunction

  // Synchronizers reset to "ack asserted" so cmd_ready stays low after reset
  // until the memory's real ack levels have propagated through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_sync <= '1;
      aw_sync <= '1;
    end else begin
      ar_sync <= {ar_sync[SYNC_STAGES-2:0], mem_ack_read};
      aw_sync <= {aw_sync[SYNC_STAGES-2:0], mem_ack_write};
    end
  end

  assign ar_s      = ar_sync[SYNC_STAGES-1];
  assign aw_s      = aw_sync[SYNC_STAGES-1];
  assign cmd_ready = (state == S_IDLE) && !ar_s && !aw_s;

  always_comb begin
    cap_data = '0;
    cap_bad  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap_data[i] = mem_data_out[2*i+1];
      if (mem_data_out[2*i+1] == mem_data_out[2*i]) cap_bad = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    tmo      = (cnt == CW'(TIMEOUT - 1));
    counting = 1'b0;
    case (state)
      S_IDLE:  if (cmd_valid && cmd_ready) state_nx = cmd_write ? S_W_REQ : S_R_REQ;
      S_W_REQ: begin
        counting = 1'b1;
        if (aw_s) state_nx = S_W_RTZ;
        else if (tmo) state_nx = S_ERR;
      end
      S_W_RTZ: begin
        counting = 1'b1;
        if (!aw_s) state_nx = S_RESP;
        else if (tmo) state_nx = S_ERR;
      end
      S_R_REQ: begin
        counting = 1'b1;
        if (ar_s) state_nx = S_R_CAP;
        else if (tmo) state_nx = S_ERR;
      end
      S_R_CAP: state_nx = S_R_ACK;
      S_R_ACK: begin
        counting = 1'b1;
        if (!ar_s) state_nx = S_R_REL;
        else if (tmo) state_nx = S_ERR;
      end
      S_R_REL: state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      S_ERR:   if (!ar_s && !aw_s) state_nx = S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      mem_addr        <= '0;
      mem_data_in     <= '0;
      mem_read_Nwrite <= '0;
      mem_ack_in_read <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_error       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      if (state == S_R_CAP) begin
        rsp_rdata <= cap_data;
        err_q     <= cap_bad;
      end
      if (state_nx != state) begin
        cnt <= '0;
        case (state_nx)
          S_W_REQ: begin
            mem_addr        <= dr_enc4(cmd_addr);
            mem_data_in     <= dr_enc8(cmd_wdata);
            mem_read_Nwrite <= 2'b01;
          end
          S_R_REQ: begin
            mem_addr        <= dr_enc4(cmd_addr);
            mem_data_in     <= '0;
            mem_read_Nwrite <= 2'b10;
          end
          S_W_RTZ, S_R_ACK, S_ERR: begin
            mem_addr        <= '0;
            mem_data_in     <= '0;
            mem_read_Nwrite <= 2'b00;
            mem_ack_in_read <= (state_nx != S_W_RTZ);
          end
          S_R_REL: mem_ack_in_read <= 1'b0;
          S_RESP: begin
            mem_ack_in_read <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_error       <= (state == S_ERR) || ((state == S_R_REL) && err_q);
            if (state != S_R_REL) rsp_rdata <= '0;
          end
          default: ;
        endcase
      end else if (counting) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_async_mem_bridge.sv
// Bench for async_mem_bridge: behavioural four-phase memory, reference array,
// directed cases plus randomized read/write traffic.
module tb_async_mem_bridge;
  localparam int SYNC = 2;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [7:0]  rsp_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data_in, mem_data_out;
  logic [1:0]  mem_read_Nwrite;
  logic        mem_ack_in_read, mem_ack_read, mem_ack_write;

  int total = 0;
  int bad   = 0;
  int mem_mode = 0;   // 0 normal, 1 never ack, 2 corrupt pair 0, 3 hold ack_read
  logic [7:0] mem_arr [16];
  logic [7:0] ref_mem [16];

  always #5 clk = ~clk;

  async_mem_bridge #(.SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read_Nwrite(mem_read_Nwrite),
    .mem_ack_in_read(mem_ack_in_read), .mem_data_out(mem_data_out),
    .mem_ack_read(mem_ack_read), .mem_ack_write(mem_ack_write)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc8(input logic [7:0] v);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 8; i++) r = r | ((v[i] ? 16'd2 : 16'd1) << (2 * i));
    return r;
  endfunction

  function automatic logic [7:0] enc4(input logic [3:0] v);
    logic [15:0] w;
    w = enc8({4'd0, v});
    return w[7:0];
  endfunction

  function automatic logic [7:0] odd8(input logic [15:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[2*i+1];
    return r;
  endfunction

  function automatic logic [3:0] odd4(input logic [7:0] x);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = x[2*i+1];
    return r;
  endfunction

  // Behavioural four-phase memory with random response delays.
  initial begin
    logic [15:0] rd;
    mem_ack_read  = 1'b0;
    mem_ack_write = 1'b0;
    mem_data_out  = '0;
    for (int i = 0; i < 16; i++) mem_arr[i] = 8'h00;
    forever begin
      #1;
      if (mem_mode != 1) begin
        if (mem_read_Nwrite == 2'b01 && !mem_ack_write) begin
          #($urandom_range(0, 12));
          mem_arr[odd4(mem_addr)] = odd8(mem_data_in);
          mem_ack_write = 1'b1;
        end else if (mem_read_Nwrite == 2'b00 && mem_ack_write) begin
          #($urandom_range(0, 12));
          mem_ack_write = 1'b0;
        end
        if (mem_read_Nwrite == 2'b10 && !mem_ack_read && !mem_ack_in_read) begin
          #($urandom_range(0, 12));
          rd = enc8(mem_arr[odd4(mem_addr)]);
          if (mem_mode == 2) rd[1:0] = 2'b11;
          mem_data_out = rd;
          #1 mem_ack_read = 1'b1;
        end else if (mem_ack_in_read && mem_ack_read && mem_mode != 3) begin
          #($urandom_range(0, 12));
          mem_ack_read = 1'b0;
          mem_data_out = '0;
        end
      end
    end
  end

  task automatic run_cmd(input string tag, input bit wr, input logic [3:0] a, input logic [7:0] d,
                         input bit exp_err, input bit chk_rd, input logic [7:0] exp_rd,
                         input int exp_lat);
    int n;
    bit got_req, saw_air, rdy_leak, got_rsp;
    logic [7:0]  q_addr;
    logic [15:0] q_data;
    logic [1:0]  q_rnw;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_accept"}, cmd_ready, 1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = 8'($urandom);
    got_req = 0; saw_air = 0; rdy_leak = 0; got_rsp = 0;
    q_addr = '0; q_data = '0; q_rnw = '0;
    for (n = 0; n < TO * 4 + 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_rsp = 1;
        break;
      end
      if (!got_req && mem_read_Nwrite != 2'b00) begin
        got_req = 1; q_addr = mem_addr; q_data = mem_data_in; q_rnw = mem_read_Nwrite;
      end
      if (mem_ack_in_read) saw_air = 1;
      if (cmd_ready) rdy_leak = 1;
    end
    check_val({tag, "_rsp"}, got_rsp, 1);
    if (got_rsp) begin
      check_val({tag, "_err"}, rsp_error, exp_err);
      if (wr) check_val({tag, "_rdata_wr"}, rsp_rdata, 0);
      else if (chk_rd) check_val({tag, "_rdata"}, rsp_rdata, exp_rd);
      check_val({tag, "_null"}, {mem_addr, mem_data_in, mem_read_Nwrite, mem_ack_in_read}, 0);
      if (exp_lat >= 0) check_val({tag, "_lat"}, n, exp_lat);
      @(negedge clk);
      check_val({tag, "_pulse"}, rsp_valid, 0);
    end
    check_val({tag, "_req_seen"}, got_req, 1);
    check_val({tag, "_req_addr"}, q_addr, enc4(a));
    check_val({tag, "_req_data"}, q_data, wr ? enc8(d) : 16'd0);
    check_val({tag, "_req_rnw"}, q_rnw, wr ? 2'b01 : 2'b10);
    check_val({tag, "_ack_in_read"}, saw_air, (!wr || exp_err));
    check_val({tag, "_no_overlap"}, rdy_leak, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    bit wr;
    logic [3:0] a;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(negedge clk);
    check_val("rst_outputs", {mem_addr, mem_data_in, mem_read_Nwrite, mem_ack_in_read}, 0);
    check_val("rst_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);
    check_val("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("post_rst_ready", cmd_ready, 1);

    run_cmd("wr5", 1, 4'h5, 8'hA5, 0, 0, 8'h00, -1);
    check_val("wr5_code_addr", enc4(4'h5), 8'h66);
    check_val("wr5_code_data", enc8(8'hA5), 16'h9966);
    ref_mem[5] = 8'hA5;
    run_cmd("rd5", 0, 4'h5, 8'h00, 0, 1, 8'hA5, -1);

    // Reset while the memory holds ack_read high during R_ACK.
    mem_mode = 3;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!mem_ack_in_read && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("hold_r_ack", mem_ack_in_read, 1);
    check_val("hold_rdata", rsp_rdata, 8'hA5);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_outputs", {mem_addr, mem_data_in, mem_read_Nwrite, mem_ack_in_read}, 0);
    check_val("midrst_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);
    check_val("midrst_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("held_ack_ready", cmd_ready, 0);
    end
    mem_ack_read = 1'b0;
    mem_data_out = '0;
    mem_mode = 0;
    @(negedge clk);
    check_val("sync_delay_ready", cmd_ready, 0);
    n = 0;
    while (!cmd_ready && n < SYNC + 3) begin
      @(negedge clk);
      n++;
    end
    check_val("release_ready", cmd_ready, 1);

    mem_mode = 2;
    run_cmd("rd_bad", 0, 4'h5, 8'h00, 1, 0, 8'h00, -1);
    mem_mode = 1;
    run_cmd("wr_tmo", 1, 4'h3, 8'h11, 1, 0, 8'h00, TO + 1);
    mem_mode = 0;

    run_cmd("b2b_wr", 1, 4'hF, 8'h3C, 0, 0, 8'h00, -1);
    ref_mem[15] = 8'h3C;
    run_cmd("b2b_rd", 0, 4'hF, 8'h00, 0, 1, 8'h3C, -1);

    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom);
      d  = 8'($urandom);
      if (wr) begin
        run_cmd("rnd_wr", 1, a, d, 0, 0, 8'h00, -1);
        ref_mem[a] = d;
      end else begin
        run_cmd("rnd_rd", 0, a, 8'h00, 0, 1, ref_mem[a], -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
